async_fifo_rd_packer: RTL and testbench
=======================================

# async_fifo_rd_packer

Read-side consumer of `async_fifo`, in the `rclk` domain. Pops DSIZE-bit words from the FIFO's first-word-fall-through read port, packs RATIO consecutive words into one wide beat, and presents each beat on a valid/ready stream with a per-lane keep mask. A flush request pushes out a partially filled beat, so trailing data never strands in the packer.

## Interface
- `DSIZE`, 32, FIFO word width; matches `async_fifo` DSIZE
- `RATIO`, 4, words per output beat; legal range 2..8
- `rclk`  in  1  read-domain clock; the only clock
- `rrst_n`  in  1  reset; synchronous, active-low
- `rempty`  in  1  FIFO empty flag
- `rdata`  in  DSIZE  FIFO head word; valid whenever `rempty`=0
- `rinc`  out  1  FIFO pop strobe; one word consumed per cycle high
- `i_flush`  in  1  single-cycle request to emit the partial beat
- `o_valid`  out  1  output beat valid
- `o_ready`  in  1  downstream accepts the beat
- `o_data`  out  DSIZE*RATIO  packed beat; word 0 in bits [DSIZE-1:0]
- `o_keep`  out  RATIO  lane i valid; unused lanes zero

## Operation
- State:
  - accumulator `acc` holds RATIO-1 lanes
  - lane counter `cnt` in 0..RATIO-1 gives the next lane to fill
  - `flush_pend` flag
  - one output register holding `o_data`, `o_keep` and `o_valid`
- `can_load` = !`o_valid` | `o_ready`.
- `rinc` = `rrst_n` & !`rempty` & ((`cnt` != RATIO-1 & !`flush_pend`) | `can_load`).
  - Combinational from `rempty` and `o_ready`.
  - Never high while `rempty`=1 or while in reset.
- Pop with `cnt` < RATIO-1:
  - `rdata` is written into lane `cnt` of `acc`, and `cnt` increments.
  - If `flush_pend` is set (which implies `can_load`), see flush below.
- Pop with `cnt` = RATIO-1:
  - The output register loads `o_data` = {`rdata`, `acc`} and `o_keep` = all ones.
  - `o_valid` goes to 1 and `cnt` goes to 0.
  - This requires `can_load`, which `rinc` already enforces.
- Flush:
  - `i_flush`=1 sets `flush_pend`. It stays set until served and is idempotent.
  - A flush is served in the first cycle with `flush_pend`=1 and `can_load`=1. That cycle's pop, if any, is included first. Let n = lanes filled after the pop.
    - n = RATIO: emit a full beat as normal.
    - 0 < n < RATIO: emit a beat with lanes 0..n-1 filled, remaining lanes zeroed, and `o_keep` = (1<<n)-1. Set `cnt` to 0.
    - n = 0: no beat is emitted.
  - `flush_pend` is cleared in every one of these cases.
  - `i_flush` in the same cycle that a flush is served sets `flush_pend` again.
- Output handshake:
  - A beat transfers on `o_valid` & `o_ready`.
  - `o_data`/`o_keep` are held stable while `o_valid`=1 and `o_ready`=0.
  - If nothing new loads in the transfer cycle, `o_valid` drops the following cycle.
- Reset (`rrst_n`=0 at a `rclk` edge):
  - `o_valid`, `o_data`, `o_keep`, `acc`, `cnt` and `flush_pend` all go to 0.
  - Any partial words and any undelivered beat are discarded.
  - Words still in the FIFO are unaffected; the FIFO's own reset governs them.

## Timing
- Pop of the completing word in cycle t gives `o_valid`=1 at t+1.
- Sustained throughput: one word per cycle. With `o_ready` held high, this is one beat every RATIO cycles.
- Backpressure:
  - The packer keeps popping until `cnt`=RATIO-1, then holds `rinc`=0 until `can_load`.
  - No word is ever popped without being stored.
- A flush with no concurrent pop gives the partial beat on `o_valid` one cycle after `can_load`, with `flush_pend` set.
- `rinc` gating on `o_ready` is same-cycle. There is no registered lookahead and no bubble on release.
- Boundaries:
  - `rempty` toggling mid-beat only pauses filling.
  - `cnt` wraps RATIO-1 to 0.
  - Flush with `cnt`=0 and the FIFO empty has no effect beyond clearing.

## Test plan
- Reset with `rempty`=0 -> `rinc`=0, `o_valid`=0, `o_keep`=0; first cycle after release -> `rinc`=1.
- RATIO=4, 8 words 0..7 written, `o_ready`=1 -> two beats: `o_data` = {3,2,1,0} then {7,6,5,4}, `o_keep`=4'hF each; first beat valid 1 cycle after the 4th pop.
- `o_ready`=0 with 8 words queued -> exactly 7 pops, then `rinc` stays 0 and beat {3,2,1,0} is held stable; raise `o_ready` -> 8th pop the same cycle, and beat {7,6,5,4} follows.
- Write 2 words (0xA, 0xB), pulse `i_flush` -> one beat `o_data` = {0,0,0xB,0xA}, `o_keep`=4'h3, then `cnt`=0.
- `i_flush` pulsed with the packer empty and `rempty`=1 -> no beat, `flush_pend` clears; a later 4-word burst packs normally.
- Assert `rrst_n`=0 after 3 words are packed and while a beat is held on `o_ready`=0 -> `o_valid`=0 next cycle; after release, the next 4 words form a clean beat with lane 0 = first new word.

Source files
------------

// File: rtl/async_fifo_rd_packer.sv
// rtl/async_fifo_rd_packer.sv - read-side word packer for async_fifo
//
// Pops DSIZE-bit words from a first-word-fall-through FIFO read port and packs
// RATIO of them into one wide beat on a valid/ready stream. A flush request
// emits a partially filled beat with a per-lane keep mask.
//
// Ports:
//   rclk     in   read-domain clock
//   rrst_n   in   synchronous active-low reset
//   rempty   in   FIFO empty flag
//   rdata    in   FIFO head word, valid while rempty=0
//   rinc     out  FIFO pop strobe (combinational)
//   i_flush  in   request to emit the partial beat
//   o_valid  out  output beat valid
//   o_ready  in   downstream accepts the beat
//   o_data   out  packed beat, word 0 in the low lane
//   o_keep   out  lane valid mask
module async_fifo_rd_packer #(
  parameter int DSIZE = 32,
  parameter int RATIO = 4
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DSIZE*RATIO-1:0] o_data,
  output logic [RATIO-1:0]       o_keep
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [DSIZE*(RATIO-1)-1:0] acc;
  logic [CW-1:0]              cnt;
  logic                       flush_pend;

  logic                       can_load;
  logic                       last;
  logic [CW:0]                n_fill;
  logic                       emit;
  logic [DSIZE*RATIO-1:0]     beat_data;
  logic [RATIO-1:0]           beat_keep;

  assign can_load = ~o_valid | o_ready;
  assign last     = (cnt == LAST);

  // The last lane completes a beat, so it may only be popped when the output
  // register can take it; a pending flush likewise waits for the register.
  assign rinc = rrst_n & ~rempty & ((~last & ~flush_pend) | can_load);

  // Lanes filled once this cycle's pop (if any) is included.
  assign n_fill = {1'b0, cnt} + {{CW{1'b0}}, rinc};

  assign emit = (rinc & last) | (flush_pend & can_load & (n_fill != '0));

  // Candidate beat: accumulator lanes with the popped word merged into lane
  // cnt, then lanes at or above n_fill forced to zero.
  always_comb begin
    beat_data = {{DSIZE{1'b0}}, acc};
    beat_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (rinc && cnt == CW'(i)) begin
        beat_data[i*DSIZE +: DSIZE] = rdata;
      end
      beat_keep[i] = ((CW+1)'(i) < n_fill);
      if (!beat_keep[i]) begin
        beat_data[i*DSIZE +: DSIZE] = '0;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_keep     <= '0;
    end else begin
      // A transfer this cycle empties the register unless a new beat loads.
      if (o_ready) begin
        o_valid <= 1'b0;
      end
      if (emit) begin
        o_valid <= 1'b1;
        o_data  <= beat_data;
        o_keep  <= beat_keep;
      end

      if (emit) begin
        cnt <= '0;
      end else if (rinc) begin
        cnt <= cnt + 1'b1;
      end

      for (int i = 0; i < RATIO - 1; i++) begin
        if (rinc && cnt == CW'(i)) begin
          acc[i*DSIZE +: DSIZE] <= rdata;
        end
      end

      // Served whenever can_load is high; a new request in that cycle re-arms.
      flush_pend <= i_flush | (flush_pend & ~can_load);
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// tb/tb_async_fifo_rd_packer.sv - self-checking bench for async_fifo_rd_packer
module tb_async_fifo_rd_packer;

  localparam int DSIZE = 32;
  localparam int RATIO = 4;

  typedef struct packed {
    logic [DSIZE*RATIO-1:0] d;
    logic [RATIO-1:0]       k;
  } beat_t;

  logic                   rclk = 1'b0;
  logic                   rrst_n;
  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;
  logic                   i_flush;
  logic                   o_valid;
  logic                   o_ready;
  logic [DSIZE*RATIO-1:0] o_data;
  logic [RATIO-1:0]       o_keep;

  int checks = 0;
  int errors = 0;

  // FIFO model: words written by the stimulus, popped on rinc.
  logic [DSIZE-1:0] mem [0:255];
  logic [7:0]       wr_ptr = 8'd0;
  logic [7:0]       rd_ptr = 8'd0;
  int               pop_count = 0;

  beat_t sb[$];

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr];

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (rinc) begin
      rd_ptr    <= rd_ptr + 8'd1;
      pop_count <= pop_count + 1;
    end
  end

  async_fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_keep  (o_keep)
  );

  task automatic check(input string tag, input logic [DSIZE*RATIO-1:0] obs,
                       input logic [DSIZE*RATIO-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every transferred beat against the queue head.
  always @(negedge rclk) begin
    if (rempty) check("rinc_while_empty", {127'd0, rinc}, '0);
    if (o_valid && o_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {124'd0, o_keep}, '0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", o_data, e.d);
        check("beat_keep", {124'd0, o_keep}, {124'd0, e.k});
      end
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [DSIZE-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_beat(input logic [DSIZE-1:0] w3, input logic [DSIZE-1:0] w2,
                             input logic [DSIZE-1:0] w1, input logic [DSIZE-1:0] w0,
                             input logic [RATIO-1:0] k);
    beat_t b;
    b.d = {w3, w2, w1, w0};
    b.k = k;
    sb.push_back(b);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 200 && !(sb.size() == 0 && !o_valid)) begin
      step();
      i++;
    end
    check("drain_done", {96'd0, 32'(sb.size())}, '0);
    check("drain_idle", {127'd0, o_valid}, '0);
  endtask

  initial begin
    logic [DSIZE*RATIO-1:0] held;
    int base;

    rrst_n  = 1'b0;
    i_flush = 1'b0;
    o_ready = 1'b1;

    // Reset with data waiting in the FIFO.
    for (int w = 0; w < 8; w++) write_word(32'(w));
    repeat (3) step();
    check("rst_rinc", {127'd0, rinc}, '0);
    check("rst_valid", {127'd0, o_valid}, '0);
    check("rst_keep", {124'd0, o_keep}, '0);
    check("rst_data", o_data, '0);

    // Two full beats, with first-beat latency.
    expect_beat(32'd3, 32'd2, 32'd1, 32'd0, 4'hF);
    expect_beat(32'd7, 32'd6, 32'd5, 32'd4, 4'hF);
    rrst_n = 1'b1;
    #1;
    check("release_rinc", {127'd0, rinc}, 128'd1);
    repeat (3) step();
    check("pre_beat_valid", {127'd0, o_valid}, '0);
    step();
    check("four_pops", {96'd0, 32'(pop_count)}, 128'd4);
    check("beat_latency", {127'd0, o_valid}, 128'd1);
    drain();

    // Backpressure: 7 pops, beat held stable, release pops the 8th same cycle.
    o_ready = 1'b0;
    base = pop_count;
    for (int w = 8; w < 16; w++) write_word(32'(w));
    expect_beat(32'd11, 32'd10, 32'd9, 32'd8, 4'hF);
    expect_beat(32'd15, 32'd14, 32'd13, 32'd12, 4'hF);
    repeat (12) step();
    check("bp_pops", {96'd0, 32'(pop_count - base)}, 128'd7);
    check("bp_rinc", {127'd0, rinc}, '0);
    check("bp_valid", {127'd0, o_valid}, 128'd1);
    check("bp_data", o_data, {32'd11, 32'd10, 32'd9, 32'd8});
    held = o_data;
    repeat (3) step();
    check("bp_stable", o_data, held);
    o_ready = 1'b1;
    #1;
    check("bp_release_rinc", {127'd0, rinc}, 128'd1);
    drain();
    check("bp_all_pops", {96'd0, 32'(pop_count - base)}, 128'd8);

    // Partial beat via flush.
    expect_beat(32'd0, 32'd0, 32'hB, 32'hA, 4'h3);
    write_word(32'hA);
    write_word(32'hB);
    repeat (3) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("flush_pend_set", {127'd0, dut.flush_pend}, 128'd1);
    drain();
    check("flush_cnt", {126'd0, dut.cnt}, '0);
    check("flush_pend_clr", {127'd0, dut.flush_pend}, '0);

    // Flush with nothing to send, then a normal burst.
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    step();
    check("empty_flush_pend", {127'd0, dut.flush_pend}, '0);
    check("empty_flush_valid", {127'd0, o_valid}, '0);
    expect_beat(32'h23, 32'h22, 32'h21, 32'h20, 4'hF);
    for (int w = 0; w < 4; w++) write_word(32'h20 + 32'(w));
    drain();

    // Reset mid-stream discards held beat and partial lanes.
    o_ready = 1'b0;
    for (int w = 0; w < 7; w++) write_word(32'h30 + 32'(w));
    repeat (10) step();
    check("mid_valid", {127'd0, o_valid}, 128'd1);
    check("mid_cnt", {126'd0, dut.cnt}, 128'd3);
    rrst_n = 1'b0;
    step();
    check("mid_rst_valid", {127'd0, o_valid}, '0);
    check("mid_rst_keep", {124'd0, o_keep}, '0);
    rrst_n = 1'b1;
    o_ready = 1'b1;
    expect_beat(32'h43, 32'h42, 32'h41, 32'h40, 4'hF);
    for (int w = 0; w < 4; w++) write_word(32'h40 + 32'(w));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
